// File: rtl/tick_gen.sv
// Tick generator: edge-triggered start/stop/step control of a divide-by-(div+1) enable pulse.
// Zero latency from state to eu; no backpressure, eu is a plain single-cycle enable.
module tick_gen (
  input  logic       clock,
  input  logic       reset_,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic [7:0] div,
  output logic       eu,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       start_q;
  logic       stop_q;
  logic       step_q;

  logic start_edge;
  logic stop_edge;
  logic step_edge;

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop  & ~stop_q;
  assign step_edge  = step  & ~step_q;

  // div feeds the compare directly so a mid-run change takes effect in the same cycle.
  assign eu      = ((state_q == RUN) && (cnt_q >= div)) || (state_q == STEP);
  assign running = (state_q == RUN);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
      step_q  <= step;
      case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
          if (stop_edge) begin
            state_q <= IDLE;
          end else if (start_edge) begin
            state_q <= RUN;
          end else if (step_edge) begin
            state_q <= STEP;
          end
        end
        RUN: begin
          if (stop_edge) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end else if (cnt_q >= div) begin
            cnt_q <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        STEP: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

endmodule
